// File: rtl/pc_stack_unit_if.sv
// Control strobes and status flags exchanged between the control unit and the PC/stack unit.
// The shared DATA/ADDR tristate buses stay plain inout ports on the unit itself.
interface pc_stack_unit_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned SPW = $clog2(DEPTH + 1);

  logic           PCC;
  logic           PLD;
  logic           PLA;
  logic           PBR;
  logic           PCALL;
  logic           PRET;
  logic           POD;
  logic           POA;
  logic           CLR_ERR;
  logic [SPW-1:0] SP;
  logic           STK_FULL;
  logic           STK_EMPTY;
  logic           ERR;

  modport master (
    output PCC, PLD, PLA, PBR, PCALL, PRET, POD, POA, CLR_ERR,
    input  SP, STK_FULL, STK_EMPTY, ERR
  );

  modport slave (
    input  PCC, PLD, PLA, PBR, PCALL, PRET, POD, POA, CLR_ERR,
    output SP, STK_FULL, STK_EMPTY, ERR
  );
endinterface

// File: rtl/pc_stack_unit.sv
// Parametrised program counter with relative branch and a return-address stack for CALL/RET.
// Drives PC onto the shared DATA/ADDR buses on request; flags misuse in a sticky ERR bit.
module pc_stack_unit #(
  parameter int unsigned   AW        = 8,
  parameter int unsigned   DW        = 16,
  parameter int unsigned   DEPTH     = 4,
  parameter logic [AW-1:0] RESET_VEC = '0
) (
  input  logic              CLK,
  input  logic              AR,
  inout  wire  [DW-1:0]     DATA,
  inout  wire  [AW-1:0]     ADDR,
  pc_stack_unit_if.slave    ctl
);
  localparam int unsigned SPW = $clog2(DEPTH + 1);

  logic [AW-1:0]  pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic [AW-1:0]  stack_q [DEPTH];

  logic [AW-1:0]  pc_inc;
  logic [AW-1:0]  ret_val;
  logic [AW-1:0]  data_lo;
  logic           push;
  logic           set_err;
  logic           unused_data;

  assign pc_inc      = pc_q + AW'(1);
  assign data_lo     = DATA[AW-1:0];
  assign unused_data = ^DATA;

  assign DATA = ctl.POD ? DW'(pc_q) : 'z;
  assign ADDR = ctl.POA ? pc_q      : 'z;

  assign ctl.SP        = sp_q;
  assign ctl.STK_FULL  = (sp_q == SPW'(DEPTH));
  assign ctl.STK_EMPTY = (sp_q == '0);
  assign ctl.ERR       = err_q;

  always_comb begin
    ret_val = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sp_q == SPW'(i + 1)) ret_val = stack_q[i];
    end
  end

  // Priority chain: only the highest pending strobe acts; a bus self-loop suppresses it.
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    push    = 1'b0;
    set_err = 1'b0;
    if (ctl.PRET) begin
      if (sp_q == '0) begin
        set_err = 1'b1;
      end else begin
        pc_d = ret_val;
        sp_d = sp_q - SPW'(1);
      end
    end else if (ctl.PCALL) begin
      if (ctl.POD || sp_q == SPW'(DEPTH)) begin
        set_err = 1'b1;
      end else begin
        push = 1'b1;
        pc_d = data_lo;
        sp_d = sp_q + SPW'(1);
      end
    end else if (ctl.PBR) begin
      if (ctl.POD) set_err = 1'b1;
      else         pc_d = pc_q + data_lo;
    end else if (ctl.PLD) begin
      if (ctl.POD) set_err = 1'b1;
      else         pc_d = data_lo;
    end else if (ctl.PLA) begin
      if (ctl.POA) set_err = 1'b1;
      else         pc_d = ADDR;
    end else if (ctl.PCC) begin
      pc_d = pc_inc;
    end
  end

  always_comb begin
    err_d = err_q;
    if (set_err)          err_d = 1'b1;
    else if (ctl.CLR_ERR) err_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge AR) begin
    if (!AR) begin
      pc_q  <= RESET_VEC;
      sp_q  <= '0;
      err_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (push && sp_q == SPW'(i)) stack_q[i] <= pc_inc;
      end
    end
  end
endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised program counter for the SimpleComputer datapath, successor to the 8-bit PC.
- Adds configurable address/data width, signed relative branch, and a hardware return-address stack for CALL/RET.
- Sits between the shared tristate DATA bus and ADDR bus, and drives either bus on command from the control unit.

Parameters:
- AW, 8, PC and ADDR bus width in bits (2..16).
- DW, 16, DATA bus width in bits (DW >= AW).
- DEPTH, 4, return-stack entries (1..16).
- RESET_VEC, 0, PC value loaded on reset (AW bits).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- AR  in  1  reset. **Asynchronous, active-low.**
- PCC  in  1  increment PC.
- PLD  in  1  load PC from DATA[AW-1:0].
- PLA  in  1  load PC from ADDR.
- PBR  in  1  relative branch: PC += sign-extended DATA[AW-1:0].
- PCALL  in  1  push PC+1 onto the stack, then load PC from DATA[AW-1:0].
- PRET  in  1  pop the stack into PC.
- POD  in  1  drive PC onto DATA, zero-extended to DW.
- POA  in  1  drive PC onto ADDR.
- CLR_ERR  in  1  synchronous clear of ERR.
- DATA  inout  DW  shared data bus.
- ADDR  inout  AW  shared address bus.
- SP  out  $clog2(DEPTH+1)  stack occupancy, 0..DEPTH.
- STK_FULL  out  1  SP == DEPTH.
- STK_EMPTY  out  1  SP == 0.
- ERR  out  1  sticky error flag.

Behaviour:
- **Reset (AR low, asynchronous):**
  - PC = RESET_VEC, SP = 0, ERR = 0, all stack entries = 0.
  - STK_EMPTY = 1, STK_FULL = 0.
  - Bus drivers remain purely combinational on POD/POA.
  - Reset asserted mid-operation aborts the operation; nothing is pushed or popped on that edge.
- **Bus drive (combinational, uses the current registered PC):**
  - DATA = POD ? {zeros, PC} : Z.
  - ADDR = POA ? PC : Z.
- **Command priority per rising edge:** PRET > PCALL > PBR > PLD > PLA > PCC > hold. Exactly one command takes effect; lower-priority strobes in the same cycle are ignored.
- **PCC:** PC <= PC + 1, modulo 2^AW. All-ones wraps to 0.
- **PLD:** PC <= DATA[AW-1:0].
- **PLA:** PC <= ADDR.
- **PBR:** PC <= PC + sext(DATA[AW-1:0]), modulo 2^AW.
  - AW=8, PC=0x02, DATA=0x00FE gives PC=0x00.
- **PCALL with SP < DEPTH:**
  - stack[SP] <= PC + 1 (mod 2^AW), SP <= SP + 1.
  - PC <= DATA[AW-1:0].
- **PCALL with SP == DEPTH (overflow):** PC, SP and stack unchanged; ERR <= 1.
- **PRET with SP > 0:** PC <= stack[SP-1], SP <= SP - 1.
- **PRET with SP == 0 (underflow):** PC and SP unchanged; ERR <= 1.
- **Bus self-loop:**
  - If POD = 1 while the winning command reads DATA (PLD/PBR/PCALL), or POA = 1 while PLA wins: command suppressed, PC/SP hold, ERR <= 1.
- **ERR:**
  - Set wins over CLR_ERR in the same cycle.
  - Otherwise CLR_ERR = 1 clears ERR at the edge.
- **Latency:**
  - Commands are visible on PC/bus outputs one cycle after the sampling edge.
  - SP/STK_FULL/STK_EMPTY update on the same edge as PC.
- **Back-to-back PCALL then PRET:** returns the pushed value with no bubble.

Test Plan:
- Reset, then 3 PCC cycles with POA=1 -> ADDR shows 0x00, 0x01, 0x02, 0x03. PC at 0xFF plus PCC -> 0x00.
- DATA driven 0x0040, PCALL -> PC=0x40, SP=1, stack[0]=0x04. Then PRET -> PC=0x04, SP=0, STK_EMPTY=1.
- DEPTH=4: five PCALLs -> SP stops at 4, STK_FULL=1, fifth call leaves PC unchanged, ERR=1. CLR_ERR -> ERR=0.
- PRET at SP=0 -> PC unchanged, ERR=1. Same cycle with CLR_ERR=1 -> ERR stays 1.
- PC=0x02, DATA=0x00FE, PBR -> PC=0x00. PC=0x7F, DATA=0x0001, PBR -> PC=0x80.
- PLD and PCC together -> PLD wins. POD=1 with PLD=1 -> PC holds, ERR=1. AR pulsed low between clock edges mid-call -> PC=RESET_VEC, SP=0 immediately.
